// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - round-robin USB transmit channel scheduler
// Grants one source at a time and frames its packet as PID, payload, CRC16 lo/hi.
module usb_tx_scheduler #(
    parameter int NREQ    = 2,
    parameter int MAX_LEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_pid,
    input  logic [8*NREQ-1:0]   src_data,
    input  logic [NREQ-1:0]     src_valid,
    input  logic [NREQ-1:0]     src_last,
    input  logic [NREQ-1:0]     src_zlp,
    output logic [NREQ-1:0]     src_ready,
    output logic [NREQ-1:0]     grant,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic                busy,
    output logic                pkt_done,
    output logic                len_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PID    = 3'd1,
        S_DATA   = 3'd2,
        S_CRC_LO = 3'd3,
        S_CRC_HI = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [3:0]      pid_q, pid_d;
    logic            zlp_q, zlp_d;
    logic [15:0]     crc_q, crc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pkt_done_q, pkt_done_d;
    logic            len_err_q, len_err_d;

    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    int              arb_j;

    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;

    // Reflected USB CRC16 (0xA001), one byte LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_j = int'(ptr_q) + k;
            if (arb_j >= NREQ) begin
                arb_j = arb_j - NREQ;
            end
            if (!arb_found && req[arb_j]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(arb_j);
            end
        end
    end

    assign g_valid = src_valid[gidx_q];
    assign g_last  = src_last[gidx_q];
    assign g_data  = src_data[int'(gidx_q)*8 +: 8];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        pid_d      = pid_q;
        zlp_d      = zlp_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        pkt_done_d = 1'b0;
        len_err_d  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        src_ready  = '0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gidx_d  = arb_idx;
                    pid_d   = req_pid[int'(arb_idx)*4 +: 4];
                    zlp_d   = src_zlp[arb_idx];
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                    state_d = S_PID;
                end
            end
            S_PID: begin
                tx_valid = 1'b1;
                tx_data  = {~pid_q, pid_q};
                if (tx_ready) begin
                    state_d = zlp_q ? S_CRC_LO : S_DATA;
                end
            end
            S_DATA: begin
                tx_valid          = g_valid;
                tx_data           = g_data;
                src_ready[gidx_q] = tx_ready;
                if (g_valid && tx_ready) begin
                    crc_d = crc16_byte(crc_q, g_data);
                    cnt_d = cnt_q + 1'b1;
                    if (g_last) begin
                        state_d = S_CRC_LO;
                    end else if (cnt_d == CW'(MAX_LEN)) begin
                        // Truncate: the rest of this source's bytes belong to no packet.
                        state_d   = S_CRC_LO;
                        len_err_d = 1'b1;
                    end
                end
            end
            S_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[7:0];
                if (tx_ready) begin
                    state_d = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[15:8];
                if (tx_ready) begin
                    pkt_done_d = 1'b1;
                    ptr_d      = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    crc_d      = 16'hFFFF;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            pid_q      <= 4'h0;
            zlp_q      <= 1'b0;
            crc_q      <= 16'hFFFF;
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            pid_q      <= pid_d;
            zlp_q      <= zlp_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            pkt_done_q <= pkt_done_d;
            len_err_q  <= len_err_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant    = busy ? ({{(NREQ-1){1'b0}}, 1'b1} << gidx_q) : '0;
    assign pkt_done = pkt_done_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb/tb_usb_tx_scheduler.sv - self-checking bench for usb_tx_scheduler
// Two instances (MAX_LEN 64 and 4) share stimulus; sel picks the one observed.
module tb_usb_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [7:0]  req_pid = '0;
    logic [15:0] src_data = '0;
    logic [1:0]  src_valid = '0;
    logic [1:0]  src_last = '0;
    logic [1:0]  src_zlp = '0;
    logic        tx_ready = 1'b0;

    logic [1:0]  a_src_ready, a_grant, b_src_ready, b_grant;
    logic        a_tx_valid, a_busy, a_pkt_done, a_len_err;
    logic        b_tx_valid, b_busy, b_pkt_done, b_len_err;
    logic [7:0]  a_tx_data, b_tx_data;

    bit          sel = 1'b0;
    logic [1:0]  obs_src_ready, obs_grant;
    logic        obs_tx_valid, obs_busy, obs_pkt_done, obs_len_err;
    logic [7:0]  obs_tx_data;

    always #5 clk = ~clk;

    usb_tx_scheduler #(.NREQ(2), .MAX_LEN(64)) dut_a (
        .clk(clk), .reset(reset), .req(req), .req_pid(req_pid),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_zlp(src_zlp),
        .src_ready(a_src_ready), .grant(a_grant), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
        .tx_ready(tx_ready), .busy(a_busy), .pkt_done(a_pkt_done), .len_err(a_len_err)
    );

    usb_tx_scheduler #(.NREQ(2), .MAX_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .req(req), .req_pid(req_pid),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_zlp(src_zlp),
        .src_ready(b_src_ready), .grant(b_grant), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
        .tx_ready(tx_ready), .busy(b_busy), .pkt_done(b_pkt_done), .len_err(b_len_err)
    );

    assign obs_src_ready = sel ? b_src_ready : a_src_ready;
    assign obs_grant     = sel ? b_grant     : a_grant;
    assign obs_tx_valid  = sel ? b_tx_valid  : a_tx_valid;
    assign obs_tx_data   = sel ? b_tx_data   : a_tx_data;
    assign obs_busy      = sel ? b_busy      : a_busy;
    assign obs_pkt_done  = sel ? b_pkt_done  : a_pkt_done;
    assign obs_len_err   = sel ? b_len_err   : a_len_err;

    // Source payloads, owned by the initial block; read pointers owned by the driver.
    logic [7:0]  pay_q [2][$];
    bit          last_fl [2];
    int          load_gen [2];
    int          seen_gen [2];
    int          rd_idx [2];
    bit          gap_en = 1'b0;
    bit          rdy_rand = 1'b0;

    // Monitor-owned records.
    bit          acc_n [2];
    int          n_acc = 0;
    int          n_done = 0;
    int          n_lenerr = 0;
    int          n_bad_rdy = 0;
    int          n_bad_grant = 0;
    int          cyc = 0;
    logic [7:0]  got [$];
    int          hs_cyc [$];
    logic [1:0]  grants [$];
    logic [1:0]  prev_grant = '0;

    int          n_err = 0;
    int          n_checks = 0;

    always @(negedge clk) begin
        cyc++;
        for (int s = 0; s < 2; s++) begin
            acc_n[s] = src_valid[s] && obs_src_ready[s];
            if (acc_n[s]) n_acc++;
        end
        if (obs_tx_valid && tx_ready) begin
            got.push_back(obs_tx_data);
            hs_cyc.push_back(cyc);
        end
        if (obs_pkt_done) n_done++;
        if (obs_len_err) n_lenerr++;
        if ((obs_src_ready & ~obs_grant) != 2'b00) n_bad_rdy++;
        if ($countones(obs_grant) > 1) n_bad_grant++;
        if (obs_grant != 2'b00 && obs_grant != prev_grant) grants.push_back(obs_grant);
        prev_grant = obs_grant;
    end

    always @(posedge clk) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (load_gen[s] != seen_gen[s]) begin
                seen_gen[s] = load_gen[s];
                rd_idx[s]   = 0;
            end else if (acc_n[s]) begin
                rd_idx[s]++;
            end
            if (rd_idx[s] < pay_q[s].size() && (!gap_en || $urandom_range(0, 2) != 0)) begin
                src_valid[s]       = 1'b1;
                src_data[s*8 +: 8] = pay_q[s][rd_idx[s]];
                src_last[s]        = (rd_idx[s] == pay_q[s].size() - 1) && last_fl[s];
            end else begin
                src_valid[s]       = 1'b0;
                src_data[s*8 +: 8] = 8'h00;
                src_last[s]        = 1'b0;
            end
        end
        tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_crc(input logic [7:0] d [$], input int m);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < m; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic load_src(input int s, input logic [7:0] pl [$], input bit with_last);
        pay_q[s]   = pl;
        last_fl[s] = with_last;
        load_gen[s]++;
    endtask

    task automatic run_pkt(input string tag, input int s, input logic [3:0] pid,
                           input logic [7:0] pl [$], input bit zlp, input bit with_last,
                           input int maxlen, output logic [7:0] cap [$]);
        logic [7:0] exp [$];
        logic [15:0] crc;
        int m, k, d0, le0, gb;
        bit trunc;
        m     = zlp ? 0 : ((pl.size() < maxlen) ? pl.size() : maxlen);
        trunc = !zlp && (pl.size() > maxlen || (!with_last && pl.size() >= maxlen));
        crc   = model_crc(pl, m);
        exp   = {};
        exp.push_back({~pid, pid});
        for (int i = 0; i < m; i++) exp.push_back(pl[i]);
        exp.push_back(crc[7:0]);
        exp.push_back(crc[15:8]);
        if (!zlp) load_src(s, pl, with_last);
        d0 = n_done; le0 = n_lenerr; gb = got.size();
        req_pid[s*4 +: 4] = pid;
        src_zlp[s] = zlp;
        req[s] = 1'b1;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!obs_grant[s] && k < 300);
        check({tag, "_grant"}, obs_grant[s], 1'b1);
        req[s] = 1'b0;
        k = 0;
        while (n_done == d0 && k < 3000) begin @(posedge clk); k++; end
        repeat (2) @(posedge clk);
        check({tag, "_done"}, n_done - d0, 1);
        check({tag, "_lenerr"}, n_lenerr - le0, trunc);
        check({tag, "_nbytes"}, got.size() - gb, exp.size());
        cap = {};
        for (int i = gb; i < got.size(); i++) cap.push_back(got[i]);
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), cap[i], exp[i]);
    endtask

    logic [7:0] pl [$];
    logic [7:0] cap1 [$];
    logic [7:0] cap2 [$];
    int k, b0, d0, a0, g0;

    initial begin
        // Reset state on both instances.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", {a_grant, a_src_ready, a_tx_valid, a_tx_data, a_busy, a_pkt_done, a_len_err}, 0);
        check("rst_b", {b_grant, b_src_ready, b_tx_valid, b_tx_data, b_busy, b_pkt_done, b_len_err}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Zero-length packet: C3, 00, 00 on consecutive handshakes.
        b0 = got.size();
        pl = {};
        run_pkt("zlp", 0, 4'h3, pl, 1'b1, 1'b1, 64, cap1);
        check("zlp_pid", got[b0], 8'hC3);
        check("zlp_lo", got[b0+1], 8'h00);
        check("zlp_hi", got[b0+2], 8'h00);
        check("zlp_consec", hs_cyc[b0+2] - hs_cyc[b0], 2);

        // Reset in the middle of the payload.
        pl = {};
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        load_src(1, pl, 1'b1);
        req_pid[7:4] = 4'hB;
        src_zlp[1]   = 1'b0;
        a0 = n_acc; d0 = n_done;
        req[1] = 1'b1;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!obs_grant[1] && k < 300);
        req[1] = 1'b0;
        k = 0;
        while (n_acc < a0 + 3 && k < 500) begin @(posedge clk); k++; end
        check("rstmid_progress", (n_acc - a0) >= 3, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rstmid_outs", {obs_grant, obs_src_ready, obs_tx_valid, obs_tx_data, obs_busy, obs_pkt_done, obs_len_err}, 0);
        pl = {};
        load_src(1, pl, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_nodone", n_done - d0, 0);
        check("rstmid_idle", obs_busy, 1'b0);

        // Simultaneous requests alternate starting at source 0.
        g0 = grants.size(); d0 = n_done;
        req_pid = 8'hA5;
        src_zlp = 2'b11;
        req = 2'b11;
        k = 0;
        while (n_done < d0 + 3 && k < 200) begin @(posedge clk); k++; end
        #1 req = 2'b00;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (obs_busy && k < 50);
        repeat (3) @(posedge clk);
        check("rr_done", n_done - d0 >= 3, 1'b1);
        check("rr_count", grants.size() - g0 >= 3, 1'b1);
        if (grants.size() >= g0 + 3) begin
            check("rr_g0", grants[g0], 2'b01);
            check("rr_g1", grants[g0+1], 2'b10);
            check("rr_g2", grants[g0+2], 2'b01);
        end
        src_zlp = 2'b00;

        // 8-byte payload with steady and with random tx_ready.
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_pkt("p8_rdy1", 0, 4'h1, pl, 1'b0, 1'b1, 64, cap1);
        rdy_rand = 1'b1;
        run_pkt("p8_rdyr", 0, 4'h1, pl, 1'b0, 1'b1, 64, cap2);
        check("p8_same_len", cap2.size(), cap1.size());
        for (int i = 0; i < cap1.size() && i < cap2.size(); i++)
            check($sformatf("p8_same%0d", i), cap2[i], cap1[i]);

        // Source valid gaps with random tx_ready on source 1.
        gap_en = 1'b1;
        pl = {};
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
        run_pkt("gap", 1, 4'h9, pl, 1'b0, 1'b1, 64, cap1);
        gap_en = 1'b0;
        rdy_rand = 1'b0;
        check("bad_ready", n_bad_rdy, 0);
        check("bad_grant", n_bad_grant, 0);

        // Truncation at MAX_LEN=4 on the second instance.
        @(negedge clk);
        reset = 1'b0;
        sel = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        pl = {};
        for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
        run_pkt("trunc", 0, 4'hD, pl, 1'b0, 1'b0, 4, cap1);
        repeat (5) @(posedge clk);
        #1;
        check("trunc_left", rd_idx[0], 4);
        check("trunc_idle", obs_busy, 1'b0);
        check("trunc_bad_ready", n_bad_rdy, 0);
        pl = {};
        load_src(0, pl, 1'b0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
